mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: READ_WAIT, default 3, number of cycles mem_addr is held before mem_rdata is captured (legal 1..7).
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 if_req  in  1  instruction-fetch read request, held until if_done.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 d_req  in  1  data-access request, held until d_done.
REQ-007 d_we  in  1  data access is a write (1) or read (0).
REQ-008 d_addr  in  32  data byte address.
REQ-009 d_wdata  in  32  data write value.
REQ-010 mem_rdata  in  32  memory read data.
REQ-011 mem_addr  out  32  memory address, registered.
REQ-012 mem_wr  out  1  memory write strobe, registered.
REQ-013 mem_wdata  out  32  memory write data, registered.
REQ-014 if_gnt / d_gnt  out  1 each  requester owns the memory port.
REQ-015 if_done / d_done  out  1 each  one-cycle completion pulse.
REQ-016 rdata  out  32  last captured read data.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, DONE; encoding is implementer's choice.
REQ-019 IDLE: if_req and d_req sampled; no request -> stay IDLE; any request -> latch winner's addr/we/wdata into mem_* registers, set owner, load counter, go ACCESS.
REQ-020 Arbitration SHALL be round-robin on a last-owner flag: single request -> grant it; both -> grant the one not granted last; flag updates on each grant.
REQ-021 Fetch requests SHALL always be reads; d_we is ignored when fetch owns the port.
REQ-022 ACCESS read: mem_addr held stable, mem_wr=0 for exactly READ_WAIT cycles; at the last ACCESS edge, mem_rdata captured into rdata; go DONE.
REQ-023 ACCESS write: mem_wr=1 for exactly one cycle with mem_addr/mem_wdata stable; rdata unchanged; go DONE.
REQ-024 DONE: owner's done pulses high for exactly one cycle; mem_wr=0; no arbitration; next state IDLE unconditionally.
REQ-025 Owner's gnt SHALL be high throughout ACCESS and DONE, and low in IDLE; never both gnts high.
REQ-026 Latency: request sampled in IDLE at cycle N -> done high at cycle N+1+READ_WAIT (read), N+2 (write).
REQ-027 Requester SHALL deassert req at the clock edge that ends its done cycle; a req still high in the following IDLE is treated as a new request.
REQ-028 Request inputs changing during ACCESS/DONE SHALL NOT affect mem_* or the in-flight transaction.
REQ-029 rdata SHALL hold its value until the next read completes, including across writes.
REQ-030 Counter SHALL be 3 bits; no wrap-around beyond READ_WAIT.

Reset
REQ-031 rst asserted SHALL immediately force IDLE, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, all gnt/done=0, busy=0, last-owner=data (fetch wins first tie).
REQ-032 rst mid-ACCESS SHALL abort the transaction with no done pulse and no rdata update; a write strobe SHALL drop asynchronously.

Verification
REQ-033 Fetch read: if_req=1, if_addr=0x10, mem returns 0xDEADBEEF -> mem_addr=0x10 for 3 cycles, if_done at N+4, rdata=0xDEADBEEF.
REQ-034 Data write: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_wr=1 for exactly one cycle, d_done at N+2, rdata unchanged.
REQ-035 Tie after reset: if_req=d_req=1 continuously -> grants alternate fetch, data, fetch, data; never both gnt high.
REQ-036 Reset mid-read: rst during 2nd ACCESS cycle -> no done pulse, rdata=0, busy=0 immediately, next request served normally.
REQ-037 Req held one extra cycle after done -> second identical transaction issued, confirming REQ-027.
REQ-038 READ_WAIT=1 build: fetch read -> if_done at N+2, rdata captured correctly.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester (read only)
//   and a data requester (read or write). Round-robin arbitration on a
//   last-owner flag. A read holds the address for READ_WAIT cycles and then
//   captures memory data. A write pulses the strobe for one cycle. Each
//   transaction ends with a one-cycle done pulse to its owner.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_if_req/addr     fetch request (held until o_if_done) and byte address
//   i_d_req/we/addr/wdata  data request (held until o_d_done), write flag,
//                     byte address and write value
//   i_mem_rdata       memory read data
//   o_mem_addr/wr/wdata    registered memory address, write strobe and data
//   o_if_gnt/o_d_gnt  owner of the memory port (ACCESS and DONE)
//   o_if_done/o_d_done     one-cycle completion pulses
//   o_rdata           last captured read data
//   o_busy            high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int READ_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_wdata,
  output logic        o_if_gnt,
  output logic        o_d_gnt,
  output logic        o_if_done,
  output logic        o_d_done,
  output logic [31:0] o_rdata,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Counter value loaded for a read: ACCESS lasts until it reaches zero.
  localparam logic [2:0] C_READ_LOAD = 3'(READ_WAIT - 1);

  state_t      r_state;
  logic        r_owner_d;   // 1: data owns the current transaction
  logic        r_last_d;    // 1: most recent grant went to data
  logic        r_we;        // current transaction is a write
  logic [2:0]  r_cnt;       // remaining ACCESS cycles minus one

  logic        w_any_req;
  logic        w_pick_d;
  logic        w_pick_we;

  // On a tie the requester not granted last wins; a lone request always wins.
  assign w_any_req = i_if_req | i_d_req;
  assign w_pick_d  = i_d_req & (~i_if_req | ~r_last_d);
  // Fetch is always a read, so d_we only counts when data wins.
  assign w_pick_we = w_pick_d & i_d_we;

  // Arbitration FSM with all memory-side and requester-side outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_d   <= 1'b0;
      r_last_d    <= 1'b1;   // fetch wins the first tie after reset
      r_we        <= 1'b0;
      r_cnt       <= 3'd0;
      o_mem_addr  <= 32'd0;
      o_mem_wr    <= 1'b0;
      o_mem_wdata <= 32'd0;
      o_if_gnt    <= 1'b0;
      o_d_gnt     <= 1'b0;
      o_if_done   <= 1'b0;
      o_d_done    <= 1'b0;
      o_rdata     <= 32'd0;
      o_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_d  <= w_pick_d;
            r_last_d   <= w_pick_d;
            r_we       <= w_pick_we;
            o_mem_addr <= w_pick_d ? i_d_addr : i_if_addr;
            if (w_pick_d) begin
              o_mem_wdata <= i_d_wdata;
            end
            o_mem_wr   <= w_pick_we;
            // A write needs a single ACCESS cycle.
            r_cnt      <= w_pick_we ? 3'd0 : C_READ_LOAD;
            o_if_gnt   <= ~w_pick_d;
            o_d_gnt    <= w_pick_d;
            o_busy     <= 1'b1;
            r_state    <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (r_cnt == 3'd0) begin
            // Last ACCESS edge: capture read data, drop strobe, signal done.
            if (!r_we) begin
              o_rdata <= i_mem_rdata;
            end
            o_mem_wr  <= 1'b0;
            o_if_done <= ~r_owner_d;
            o_d_done  <= r_owner_d;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        S_DONE: begin
          o_if_done <= 1'b0;
          o_d_done  <= 1'b0;
          o_if_gnt  <= 1'b0;
          o_d_gnt   <= 1'b0;
          o_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: begin
          o_mem_wr  <= 1'b0;
          o_if_done <= 1'b0;
          o_d_done  <= 1'b0;
          o_if_gnt  <= 1'b0;
          o_d_gnt   <= 1'b0;
          o_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A transaction-level model (phase
//   counter per granted transaction) predicts outputs checked every cycle; the
//   directed tests also pin latencies, strobe counts, grant order and data
//   with hand-computed literals. A second instance is built with READ_WAIT=1.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int RW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic        mem_wr, if_gnt, d_gnt, if_done, d_done, busy;

  // READ_WAIT=1 instance signals
  logic        r1_if_req, r1_d_req, r1_d_we;
  logic [31:0] r1_if_addr, r1_d_addr, r1_d_wdata;
  logic [31:0] r1_mem_rdata, r1_mem_addr, r1_mem_wdata, r1_rdata;
  logic        r1_mem_wr, r1_if_gnt, r1_d_gnt, r1_if_done, r1_d_done, r1_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // Memory contents: 0x10 holds 0xDEADBEEF, everything else a pattern.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    else return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata    = mem_f(mem_addr);
  assign r1_mem_rdata = mem_f(r1_mem_addr);

  mem_port_arbiter #(.READ_WAIT(RW)) u_dut (
    .clk(clk), .rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_mem_rdata(mem_rdata),
    .o_mem_addr(mem_addr), .o_mem_wr(mem_wr), .o_mem_wdata(mem_wdata),
    .o_if_gnt(if_gnt), .o_d_gnt(d_gnt), .o_if_done(if_done), .o_d_done(d_done),
    .o_rdata(rdata), .o_busy(busy)
  );

  mem_port_arbiter #(.READ_WAIT(1)) u_rw1 (
    .clk(clk), .rst(rst),
    .i_if_req(r1_if_req), .i_if_addr(r1_if_addr),
    .i_d_req(r1_d_req), .i_d_we(r1_d_we), .i_d_addr(r1_d_addr), .i_d_wdata(r1_d_wdata),
    .i_mem_rdata(r1_mem_rdata),
    .o_mem_addr(r1_mem_addr), .o_mem_wr(r1_mem_wr), .o_mem_wdata(r1_mem_wdata),
    .o_if_gnt(r1_if_gnt), .o_d_gnt(r1_d_gnt), .o_if_done(r1_if_done), .o_d_done(r1_d_done),
    .o_rdata(r1_rdata), .o_busy(r1_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_phase counts cycles since the grant edge: 1..m_len-1 are ACCESS,
  // m_len is the done cycle, 0 means idle.
  int          m_phase, m_len;
  bit          m_owner_d, m_last_d, m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_len = 0; m_owner_d = 1'b0; m_last_d = 1'b1;
      m_write = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_rdata = 32'd0;
    end else if (m_phase == 0) begin
      if (if_req || d_req) begin
        if (if_req && d_req) m_owner_d = !m_last_d;
        else m_owner_d = d_req;
        m_last_d = m_owner_d;
        m_write  = m_owner_d && d_we;
        m_addr   = m_owner_d ? d_addr : if_addr;
        if (m_write) m_wdata = d_wdata;
        m_len    = m_write ? 2 : RW + 1;
        m_phase  = 1;
      end
    end else if (m_phase == m_len) begin
      m_phase = 0;
    end else begin
      if (m_phase == m_len - 1 && !m_write) m_rdata = mem_f(m_addr);
      m_phase++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    bit act, acc, dn;
    if (cmp_en) begin
      act = (m_phase != 0);
      acc = act && (m_phase < m_len);
      dn  = act && (m_phase == m_len);
      check("busy",    {31'd0, busy},    {31'd0, act});
      check("if_gnt",  {31'd0, if_gnt},  {31'd0, act && !m_owner_d});
      check("d_gnt",   {31'd0, d_gnt},   {31'd0, act && m_owner_d});
      check("if_done", {31'd0, if_done}, {31'd0, dn && !m_owner_d});
      check("d_done",  {31'd0, d_done},  {31'd0, dn && m_owner_d});
      check("mem_wr",  {31'd0, mem_wr},  {31'd0, acc && m_write});
      check("rdata",   rdata, m_rdata);
      if (act) check("mem_addr", mem_addr, m_addr);
      if (acc && m_write) check("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // Runs one transaction on the main DUT following the requester protocol.
  task automatic run_one(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output int acc_n,
                         output int wr_n);
    int n;
    bit got;
    n = cyc; lat = -1; acc_n = 0; wr_n = 0; got = 1'b0;
    if (is_d) begin d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1; end
    else begin if_addr = addr; if_req = 1'b1; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((is_d ? d_gnt : if_gnt) && !(is_d ? d_done : if_done) && mem_addr == addr && !mem_wr) acc_n++;
      if (mem_wr && mem_addr == addr && mem_wdata == wd) wr_n++;
      if (is_d ? d_done : if_done) begin lat = cyc - n; got = 1'b1; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done pulse within 40 cycles");
    end
    @(posedge clk); #2;
    d_req = 1'b0; if_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, acc_n, wr_n, k, both, dcount, n;
    int seq[4];
    bit pg, got;

    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    r1_if_req = 1'b0; r1_d_req = 1'b0; r1_d_we = 1'b0;
    r1_if_addr = 32'd0; r1_d_addr = 32'd0; r1_d_wdata = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_gnts", {30'd0, if_gnt, d_gnt}, 32'd0);
    check("rst_dones", {30'd0, if_done, d_done}, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick(); tick();

    // Fetch read of 0x10
    run_one(1'b0, 1'b0, 32'h10, 32'd0, lat, acc_n, wr_n);
    check("fetch_latency", lat, 32'd4);
    check("fetch_addr_cycles", acc_n, 32'd3);
    tick();
    check("fetch_rdata", rdata, 32'hDEADBEEF);

    // Data write of 0x12345678 to 0x40
    run_one(1'b1, 1'b1, 32'h40, 32'h12345678, lat, acc_n, wr_n);
    check("write_latency", lat, 32'd2);
    check("write_strobe_cycles", wr_n, 32'd1);
    tick();
    check("write_rdata_kept", rdata, 32'hDEADBEEF);

    // Data read of 0x80
    run_one(1'b1, 1'b0, 32'h80, 32'd0, lat, acc_n, wr_n);
    check("dread_latency", lat, 32'd4);
    tick();
    check("dread_rdata", rdata, 32'h0080FF7F);

    // Tie after reset: grants alternate starting with fetch
    rst = 1'b1; tick(); rst = 1'b0; tick();
    if_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    k = 0; both = 0; pg = 1'b0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      @(negedge clk);
      if ((if_gnt || d_gnt) && !pg) begin seq[k] = d_gnt ? 1 : 0; k++; end
      pg = if_gnt || d_gnt;
      if (if_gnt && d_gnt) both++;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) both++;
      if (d_done) got = 1'b1;
    end
    @(posedge clk); #2;
    if_req = 1'b0; d_req = 1'b0;
    check("tie_grants", k, 32'd4);
    check("tie_seq0", seq[0], 32'd0);
    check("tie_seq1", seq[1], 32'd1);
    check("tie_seq2", seq[2], 32'd0);
    check("tie_seq3", seq[3], 32'd1);
    check("tie_both_gnt", both, 32'd0);
    check("tie_last_done", {31'd0, got}, 32'd1);
    tick();
    check("tie_rdata", rdata, 32'h0200FDFF);

    // Reset during 2nd ACCESS cycle of a fetch read
    if_addr = 32'h10; if_req = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_gnt", {31'd0, if_gnt}, 32'd0);
    if_req = 1'b0;
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_done) dcount++;
    end
    check("abort_no_done", dcount, 32'd0);
    #2 rst = 1'b0;
    tick();
    run_one(1'b0, 1'b0, 32'h10, 32'd0, lat, acc_n, wr_n);
    check("after_abort_latency", lat, 32'd4);
    tick();
    check("after_abort_rdata", rdata, 32'hDEADBEEF);

    // Reset during a write strobe drops it immediately
    d_we = 1'b1; d_addr = 32'h48; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
    tick();
    check("wr_strobe_high", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1;
    #1;
    check("wr_strobe_async_drop", {31'd0, mem_wr}, 32'd0);
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Request held one cycle past done issues a second identical write
    d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h0BADF00D; d_req = 1'b1;
    dcount = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (d_done) begin dcount++; got = 1'b1; end
    end
    tick();          // done -> idle, request still high
    tick();          // idle samples the held request
    d_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d_done) dcount++;
    end
    check("held_req_dones", dcount, 32'd2);
    tick();

    // READ_WAIT=1 instance
    n = cyc; r1_if_addr = 32'h10; r1_if_req = 1'b1; lat = -1; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (r1_if_done) begin lat = cyc - n; got = 1'b1; end
    end
    @(posedge clk); #2 r1_if_req = 1'b0;
    check("rw1_latency", lat, 32'd2);
    tick();
    check("rw1_rdata", r1_rdata, 32'hDEADBEEF);
    n = cyc; r1_if_addr = 32'h80; r1_if_req = 1'b1; lat = -1; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (r1_if_done) begin lat = cyc - n; got = 1'b1; end
    end
    @(posedge clk); #2 r1_if_req = 1'b0;
    check("rw1_latency2", lat, 32'd2);
    tick();
    check("rw1_rdata2", r1_rdata, 32'h0080FF7F);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
